// File: rtl/sram_controller.sv
// 32-bit CPU memory-stage port onto a 16-bit asynchronous SRAM; each word is two halfword accesses.
// Optional one-entry read-hit tag enabled by defining SRAM_READ_HIT_EN.
module sram_controller #(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   inout  logic [15:0] SRAM_DQ,
   output logic [17:0] SRAM_ADDR,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N,
   output logic        SRAM_WE_N,
   output logic        SRAM_CE_N,
   output logic        SRAM_OE_N
);

   typedef enum logic [2:0] {
      IDLE,
      RD_LO,
      RD_HI,
      WR_LO,
      WR_HI,
      DONE
   } state_t;

   localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [17:0] idx_q, idx_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;

   logic [31:0] addr_diff;
   logic [17:0] idx_calc;
   logic        last_cyc;
   logic        hit;
   logic        dq_oe;
   logic [15:0] dq_out;
   logic        unused_bits;

   // Halfword index keeps bits [18:2] of the byte offset; bit 0 selects the half.
   assign addr_diff   = address - BASE_ADDR;
   assign idx_calc    = {addr_diff[18:2], 1'b0};
   assign unused_bits = ^{addr_diff[31:19], addr_diff[1:0]};
   assign last_cyc    = (cnt_q == LAST_CNT);

`ifdef SRAM_READ_HIT_EN
   logic [31:0] tag_q, tag_d;
   logic        tag_vld_q, tag_vld_d;
   logic [31:0] raddr_q, raddr_d;

   assign hit = rd_en && !wr_en && tag_vld_q && (address == tag_q);

   always_comb begin
      tag_d     = tag_q;
      tag_vld_d = tag_vld_q;
      raddr_d   = raddr_q;
      if (state_q == IDLE && wr_en) begin
         tag_vld_d = 1'b0;
      end
      if (state_q == IDLE && rd_en && !wr_en && !hit) begin
         raddr_d = address;
      end
      if (state_q == RD_HI && last_cyc) begin
         tag_d     = raddr_q;
         tag_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tag_q     <= '0;
         tag_vld_q <= 1'b0;
         raddr_q   <= '0;
      end else begin
         tag_q     <= tag_d;
         tag_vld_q <= tag_vld_d;
         raddr_q   <= raddr_d;
      end
   end
`else
   assign hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (wr_en) begin
               state_d = WR_LO;
               idx_d   = idx_calc;
               wdata_d = write_data;
            end else if (rd_en && !hit) begin
               state_d = RD_LO;
               idx_d   = idx_calc;
            end
         end
         RD_LO: begin
            if (last_cyc) begin
               rdata_d[15:0] = SRAM_DQ;
               state_d       = RD_HI;
               cnt_d         = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         RD_HI: begin
            if (last_cyc) begin
               rdata_d[31:16] = SRAM_DQ;
               state_d        = DONE;
               cnt_d          = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         WR_LO: begin
            if (last_cyc) begin
               state_d = WR_HI;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         WR_HI: begin
            if (last_cyc) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      ready     = 1'b0;
      SRAM_ADDR = '0;
      SRAM_UB_N = 1'b1;
      SRAM_LB_N = 1'b1;
      SRAM_WE_N = 1'b1;
      SRAM_CE_N = 1'b1;
      SRAM_OE_N = 1'b1;
      dq_oe     = 1'b0;
      dq_out    = '0;
      unique case (state_q)
         IDLE: ready = !(rd_en || wr_en) || hit;
         RD_LO, RD_HI: begin
            SRAM_ADDR = (state_q == RD_HI) ? {idx_q[17:1], 1'b1} : idx_q;
            SRAM_CE_N = 1'b0;
            SRAM_UB_N = 1'b0;
            SRAM_LB_N = 1'b0;
            SRAM_OE_N = 1'b0;
         end
         WR_LO, WR_HI: begin
            SRAM_ADDR = (state_q == WR_HI) ? {idx_q[17:1], 1'b1} : idx_q;
            SRAM_CE_N = 1'b0;
            SRAM_UB_N = 1'b0;
            SRAM_LB_N = 1'b0;
            SRAM_WE_N = 1'b0;
            dq_oe     = 1'b1;
            dq_out    = (state_q == WR_HI) ? wdata_q[31:16] : wdata_q[15:0];
         end
         DONE: ready = 1'b1;
         default: ready = 1'b0;
      endcase
   end

   assign SRAM_DQ   = dq_oe ? dq_out : 'z;
   assign read_data = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural 1K-halfword SRAM on the data bus.
// Honours SRAM_READ_HIT_EN when compiled with the same define as the design.
module tb_sram_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;
   wire  [15:0] SRAM_DQ;
   logic [17:0] SRAM_ADDR;
   logic        SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N;

   logic [15:0] mem [0:1023];
   int checks = 0;
   int errors = 0;
   int lat;

   sram_controller #(.WAIT_CYCLES(2), .BASE_ADDR(32'd1024)) dut (
      .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
      .address(address), .write_data(write_data),
      .read_data(read_data), .ready(ready),
      .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR),
      .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N), .SRAM_WE_N(SRAM_WE_N),
      .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N)
   );

   always #5 clk = ~clk;

   assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR[9:0]] : 16'hzzzz;

   always @(posedge clk) begin
      if (!SRAM_CE_N && !SRAM_WE_N) mem[SRAM_ADDR[9:0]] <= SRAM_DQ;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_bus_idle(input string tag);
      chk({tag, "_strobes"}, {27'd0, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N}, 32'h1f);
      chk({tag, "_addr"}, {14'd0, SRAM_ADDR}, 32'd0);
      chk({tag, "_dq"}, {16'd0, SRAM_DQ}, 32'h0000zzzz);
   endtask

   task automatic chk_wr_cycle(input string tag, input logic [17:0] a, input logic [15:0] d);
      chk({tag, "_addr"}, {14'd0, SRAM_ADDR}, {14'd0, a});
      chk({tag, "_dq"}, {16'd0, SRAM_DQ}, {16'd0, d});
      chk({tag, "_we_oe_ce"}, {29'd0, SRAM_WE_N, SRAM_OE_N, SRAM_CE_N}, 32'b010);
      chk({tag, "_ready"}, {31'd0, ready}, 32'd0);
   endtask

   // Finish a transaction already in flight; returns cycles waited.
   task automatic wait_ready(output int n);
      n = 0;
      while (!ready && n < 20) begin
         tick();
         n++;
      end
      rd_en = 1'b0;
      wr_en = 1'b0;
      tick();
   endtask

   task automatic run(input logic do_rd, input logic do_wr, input logic [31:0] a,
                      input logic [31:0] d, output int n);
      address    = a;
      write_data = d;
      rd_en      = do_rd;
      wr_en      = do_wr;
      #1;
      wait_ready(n);
   endtask

   initial begin
      rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
      #1;
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_rdata", read_data, 32'd0);
      chk_bus_idle("rst");
      tick(); tick();
      rst = 1'b1;
      tick();

      // Write 0xDEADBEEF to 1024, checked cycle by cycle.
      address = 32'd1024; write_data = 32'hDEADBEEF; wr_en = 1'b1;
      #1;
      chk("w0_ready", {31'd0, ready}, 32'd0);
      for (int c = 1; c <= 4; c++) begin
         tick();
         chk_wr_cycle("w_beef", (c <= 2) ? 18'd0 : 18'd1, (c <= 2) ? 16'hBEEF : 16'hDEAD);
      end
      tick();
      chk("w5_ready", {31'd0, ready}, 32'd1);
      chk_bus_idle("w5");
      wr_en = 1'b0;
      tick();
      chk("w_idle_ready", {31'd0, ready}, 32'd1);

      run(1'b1, 1'b0, 32'd1024, 32'd0, lat);
      chk("rd1024_lat", lat, 32'd5);
      chk("rd1024_data", read_data, 32'hDEADBEEF);

      run(1'b1, 1'b0, 32'd1024, 32'd0, lat);
`ifdef SRAM_READ_HIT_EN
      chk("rd1024_rep_lat", lat, 32'd0);
`else
      chk("rd1024_rep_lat", lat, 32'd5);
`endif
      chk("rd1024_rep_data", read_data, 32'hDEADBEEF);

      // Read and write together at 1028: the write must win.
      address = 32'd1028; write_data = 32'h12345678; rd_en = 1'b1; wr_en = 1'b1;
      #1;
      chk("both_ready0", {31'd0, ready}, 32'd0);
      tick();
      chk_wr_cycle("both_lo", 18'd2, 16'h5678);
      tick(); tick();
      chk_wr_cycle("both_hi", 18'd3, 16'h1234);
      wait_ready(lat);
      chk("both_lat", lat, 32'd2);
      chk("both_rdata_held", read_data, 32'hDEADBEEF);
      run(1'b1, 1'b0, 32'd1028, 32'd0, lat);
      chk("rd1028_lat", lat, 32'd5);
      chk("rd1028_data", read_data, 32'h12345678);
      run(1'b1, 1'b0, 32'd1024, 32'd0, lat);
      chk("rd1024_after_wr_lat", lat, 32'd5);
      chk("rd1024_after_wr_data", read_data, 32'hDEADBEEF);

      // Address below BASE_ADDR wraps to the top of the halfword space.
      address = 32'd1020; write_data = 32'h5A5AA5A5; wr_en = 1'b1;
      #1;
      tick();
      chk_wr_cycle("wrap_lo", 18'h3FFFE, 16'hA5A5);
      wait_ready(lat);
      run(1'b1, 1'b0, 32'd1020, 32'd0, lat);
      chk("wrap_rd_lat", lat, 32'd5);
      chk("wrap_rd_data", read_data, 32'h5A5AA5A5);

      // Reset during the second cycle of a write: only the low half lands.
      run(1'b0, 1'b1, 32'd1032, 32'h22221111, lat);
      address = 32'd1032; write_data = 32'hAAAA5555; wr_en = 1'b1;
      #1;
      tick();
      chk_wr_cycle("abort_c1", 18'd4, 16'h5555);
      tick();
      rst = 1'b0; wr_en = 1'b0;
      #1;
      chk("abort_ready", {31'd0, ready}, 32'd1);
      chk("abort_rdata", read_data, 32'd0);
      chk_bus_idle("abort");
      tick();
      rst = 1'b1;
      tick();
      run(1'b1, 1'b0, 32'd1032, 32'd0, lat);
      chk("abort_rd_lat", lat, 32'd5);
      chk("abort_rd_data", read_data, 32'h22225555);

      // Inputs changed mid-stall must not affect the access in flight.
      run(1'b0, 1'b1, 32'd2048, 32'h88887777, lat);
      address = 32'd1024; write_data = 32'hCAFEF00D; wr_en = 1'b1;
      #1;
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (c == 1) begin
            address    = 32'd2048;
            write_data = 32'hFFFFFFFF;
         end
         chk_wr_cycle("stall", (c <= 2) ? 18'd0 : 18'd1, (c <= 2) ? 16'hF00D : 16'hCAFE);
      end
      wait_ready(lat);
      chk("stall_lat", lat, 32'd1);
      run(1'b1, 1'b0, 32'd2048, 32'd0, lat);
      chk("rd2048_data", read_data, 32'h88887777);
      run(1'b1, 1'b0, 32'd1024, 32'd0, lat);
      chk("rd1024_new_data", read_data, 32'hCAFEF00D);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: SRAM clock cycles held per 16-bit access (legal 1..15).
REQ-002 Parameter BASE_ADDR, default 32'd1024: CPU byte address mapped to SRAM halfword 0.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 rd_en  input  1  memory-stage read request, held until ready.
REQ-006 wr_en  input  1  memory-stage write request, held until ready.
REQ-007 address  input  32  CPU byte address, word-aligned.
REQ-008 write_data  input  32  store data.
REQ-009 read_data  output  32  load data, valid while ready=1 after a read.
REQ-010 ready  output  1  0 = stall pipeline; 1 = request complete or idle.
REQ-011 SRAM_DQ  inout  16  SRAM data bus.
REQ-012 SRAM_ADDR  output  18  SRAM halfword address.
REQ-013 SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N  output  1 each  active-low SRAM strobes.

Function
REQ-014 States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
REQ-015 IDLE: wr_en=1 -> WR_LO; else rd_en=1 -> RD_LO; else stay; write wins if both asserted.
REQ-016 ready = 1 in IDLE with no request and in DONE; 0 combinationally in IDLE with a request and in all other states.
REQ-017 Each of RD_LO/RD_HI/WR_LO/WR_HI lasts exactly WAIT_CYCLES cycles via internal counter; LO -> HI -> DONE; DONE -> IDLE after one cycle.
REQ-018 Request cycle = cycle 0: ready=1 in cycle 2*WAIT_CYCLES+1 (5 at default), for exactly one cycle.
REQ-019 Halfword index = (address - BASE_ADDR) >> 1, 32-bit subtract, truncated to 18 bits with bit 0 forced 0; LO state drives index, HI drives index|1.
REQ-020 Out-of-range address (below BASE_ADDR) wraps modulo 2^18; no error flag.
REQ-021 Access states: SRAM_CE_N=0, SRAM_UB_N=0, SRAM_LB_N=0; IDLE/DONE: all strobes 1, SRAM_ADDR=0.
REQ-022 Read states: SRAM_OE_N=0, SRAM_WE_N=1, SRAM_DQ high-Z; SRAM_DQ sampled on last cycle of RD_LO into read_data[15:0], of RD_HI into read_data[31:16].
REQ-023 Write states: SRAM_OE_N=1, SRAM_WE_N=0, SRAM_DQ driven with write_data[15:0] in WR_LO, write_data[31:16] in WR_HI; high-Z otherwise.
REQ-024 address/write_data latched at request acceptance; changes during stall ignored.
REQ-025 read_data holds last read value until next read completes; writes do not modify it.
REQ-026 rd_en/wr_en still high in the cycle after DONE start a new transaction (master must drop them when ready).

Reset
REQ-027 rst=0 asynchronously forces IDLE, counter 0, read_data 0, all SRAM strobes 1, SRAM_ADDR 0, SRAM_DQ high-Z, ready=1.
REQ-028 Reset mid-transaction aborts it; a partial write may leave low halfword updated; no retry.

Configuration
REQ-029 Macro SRAM_READ_HIT_EN: when defined, a one-entry tag (address + valid) records last completed read.
REQ-030 With SRAM_READ_HIT_EN: read in IDLE whose address equals valid tag returns read_data with ready=1 in cycle 0, no SRAM access; any accepted write or reset clears valid.
REQ-031 Without SRAM_READ_HIT_EN: every read takes full REQ-018 latency; no tag logic.

Verification
REQ-032 Write 0xDEADBEEF to 1024, WAIT_CYCLES=2 -> SRAM_ADDR 0 with DQ 0xBEEF cycles 1-2, SRAM_ADDR 1 with DQ 0xDEAD cycles 3-4, ready=1 cycle 5.
REQ-033 Then read 1024 -> read_data=0xDEADBEEF, ready=1 cycle 5; repeat read -> cycle 0 with macro, cycle 5 without.
REQ-034 rd_en and wr_en together at 1028, write_data 0x12345678 -> WE_N low, halfwords 2/3 written, subsequent read returns 0x12345678.
REQ-035 Assert rst=0 in cycle 2 of a write -> same-cycle strobes all 1, DQ high-Z, ready=1; later read of same word returns low half new, high half old.
REQ-036 Change address during stall from 1024 to 2048 -> SRAM_ADDR stays 0/1; read of 2048 unaffected.
